mem_access_unit: RTL and testbench
==================================

# mem_access_unit

Load/store sequencer between the CPU datapath and the word-addressed data memory. It accepts one byte, halfword or word access per handshake. Sub-word stores become a read-modify-write of the containing word. Loads are byte-lane extracted and zero- or sign-extended. Responses return to the CPU as a one-cycle pulse, and `req_ready` stalls the pipeline while an access is in flight.

## Interface
Parameters:
- `AW`, 32: address width; memory word index is `addr[AW-1:2]`.

Ports:
- `clk` in 1: rising-edge clock.
- `reset_n` in 1: synchronous, active-low reset.
- `req_valid` in 1: CPU access request.
- `req_ready` out 1: unit can accept a request; high only in IDLE and while `reset_n`=1.
- `req_we` in 1: 1 = store, 0 = load.
- `req_size` in 2: 00 byte, 01 half, 10 word, 11 reserved.
- `req_signed` in 1: sign-extend loads.
- `req_addr` in AW: byte address.
- `req_wdata` in 32: store data, right-justified.
- `resp_valid` out 1: one-cycle completion pulse.
- `resp_rdata` out 32: extended load data; 0 for stores and errors.
- `resp_err` out 1: misaligned or reserved-size access, valid with `resp_valid`.
- `dmem_we` out 1: memory write enable.
- `dmem_a` out AW: memory byte address, always word-aligned (`[1:0]`=0).
- `dmem_wd` out 32: memory write data.
- `dmem_rd` in 32: memory read data, combinational from `dmem_a`.

## Operation
- States: IDLE, RD, RMW_RD, WR, RESP.
- Handshake fires when `req_valid & req_ready`. On accept, latch we, size, signed, addr and wdata; check alignment.
- Misaligned: half with `addr[0]`=1, word with `addr[1:0]`≠0, or size 11.
- IDLE transitions on accept:
  - Error → RESP with err=1; no memory access.
  - Load → RD.
  - Word store → WR.
  - Byte or half store → RMW_RD.
- RD: drive `dmem_a`. Capture the lane `(addr[1:0]*8)` of `dmem_rd` and extend to 32 bits (zero, or sign when `req_signed`). Then → RESP.
- RMW_RD: drive `dmem_a` and capture `dmem_rd` as the old word. Then → WR.
- WR: `dmem_we`=1 and `dmem_a` driven.
  - `dmem_wd` = wdata for word stores.
  - For sub-word stores, `dmem_wd` = old word with the addressed byte (`wdata[7:0]`) or halfword (`wdata[15:0]`) replaced.
  - Then → RESP.
- RESP: `resp_valid`=1 for one cycle, then → IDLE. There is no response back-pressure.
- Little-endian byte lanes: byte k occupies bits `[8k+7:8k]`; half at `addr[1]` occupies `[16*addr[1]+15 : 16*addr[1]]`.
- Outside RD, RMW_RD and WR: `dmem_we`=0, `dmem_a`=0, `dmem_wd`=0.
- `req_signed` is ignored for word loads and for stores.

## Timing
- Accept at edge T (request presented in cycle T).
- Completion (`resp_valid` high):
  - Error: cycle T+1.
  - Load and word store: cycle T+2.
  - Sub-word store: cycle T+3.
- Next accept is possible in the cycle after RESP. Maximum throughput: one load per 3 cycles.
- Memory write commits at the clock edge that ends the WR cycle.
- Reset (`reset_n`=0 sampled at an edge): state → IDLE.
  - Outputs held at reset values: `req_ready`=0, `resp_valid`=0, `resp_rdata`=0, `resp_err`=0, `dmem_we`=0, `dmem_a`=0, `dmem_wd`=0.
  - `dmem_we` is gated by `reset_n`, so reset asserted during WR suppresses the write.
  - An in-flight access is dropped with no response.
- `req_*` inputs are sampled only at accept; later changes have no effect.

## Configuration
- `MEM_ACCESS_ALIGN_CHECK_EN` defined: misaligned and reserved-size requests complete with `resp_err`=1 at T+1, with no memory access.
- Not defined: `resp_err` is tied 0. Low address bits are forced to the size's natural alignment (half: `addr[0]`=0; word: `addr[1:0]`=0), and the access proceeds normally. Size 11 is treated as word.

## Test plan
- Word store `addr`=0x10, `wdata`=0xDEADBEEF, then word load 0x10: `dmem_we` is high for exactly one cycle at T+1, with `dmem_a`=0x10. The load returns 0xDEADBEEF at T+2.
- Memory word 0x20 = 0x11223344; byte store `addr`=0x22, `wdata`=0xAA: the RMW write is 0x11AA3344, and `resp_valid` fires at T+3.
- Memory word 0x30 = 0x80F0017F. Expected load results:
  - Signed byte at 0x30 → 0x0000007F.
  - Signed byte at 0x33 → 0xFFFFFF80.
  - Unsigned half at 0x32 → 0x000080F0.
  - Signed half at 0x32 → 0xFFFF80F0.
- With the macro defined, a half store at 0x41 returns `resp_err`=1 at T+1, with `dmem_we` never asserted and memory unchanged. Without the macro, the same store writes the half at 0x40.
- `req_valid` held high continuously: `req_ready` is low from T+1 through RESP, and no second accept occurs before IDLE.
- `reset_n`=0 asserted during the RMW_RD cycle of a byte store: there is no write, no `resp_valid`, and all outputs read 0. After release, `req_ready`=1 and the next load completes normally.

Source files
------------

// File: rtl/mem_access_if.sv
// CPU load/store handshake plus data-memory port bundle for mem_access_unit.
// slave = the access unit; master = CPU/memory side driving requests and dmem_rd.
interface mem_access_if #(
  parameter int AW = 32
);
  logic          req_valid;
  logic          req_ready;
  logic          req_we;
  logic [1:0]    req_size;
  logic          req_signed;
  logic [AW-1:0] req_addr;
  logic [31:0]   req_wdata;
  logic          resp_valid;
  logic [31:0]   resp_rdata;
  logic          resp_err;
  logic          dmem_we;
  logic [AW-1:0] dmem_a;
  logic [31:0]   dmem_wd;
  logic [31:0]   dmem_rd;

  modport master (
    output req_valid, req_we, req_size, req_signed, req_addr, req_wdata, dmem_rd,
    input  req_ready, resp_valid, resp_rdata, resp_err, dmem_we, dmem_a, dmem_wd
  );

  modport slave (
    input  req_valid, req_we, req_size, req_signed, req_addr, req_wdata, dmem_rd,
    output req_ready, resp_valid, resp_rdata, resp_err, dmem_we, dmem_a, dmem_wd
  );
endinterface

// File: rtl/mem_access_unit.sv
// Load/store sequencer: byte/half/word accesses, sub-word stores as read-modify-write.
// MEM_ACCESS_ALIGN_CHECK_EN: misaligned/reserved-size requests answer with resp_err; otherwise addresses are force-aligned.
//
//   state  | meaning
//   IDLE   | ready for a request
//   RD     | load: read word, extract and extend lane
//   RMW_RD | sub-word store: read old word
//   WR     | write merged or full word
//   RESP   | one-cycle completion pulse
module mem_access_unit #(
  parameter int AW = 32
) (
  input  logic       clk,
  input  logic       reset_n,
  mem_access_if.slave bus
);

  typedef enum logic [2:0] {IDLE, RD, RMW_RD, WR, RESP} state_t;

  state_t        state, state_nx;
  logic          we_q, signed_q, err_q;
  logic [1:0]    size_q;
  logic [AW-1:0] addr_q;
  logic [31:0]   wdata_q, old_q, rdata_q;
  logic          accept;
  logic          err_d;
  logic [1:0]    size_d;
  logic [AW-1:0] addr_d;
  logic [4:0]    lane_sh;
  logic [31:0]   lane, load_ext, lane_mask, store_word;
  logic [AW-1:0] word_a;
  logic          ready, rv, dwe;
  logic [AW-1:0] da;
  logic [31:0]   dwd;

  assign accept = bus.req_valid & reset_n & (state == IDLE);

`ifdef MEM_ACCESS_ALIGN_CHECK_EN
  assign err_d  = (bus.req_size == 2'b11)
                | ((bus.req_size == 2'b01) & bus.req_addr[0])
                | ((bus.req_size == 2'b10) & (bus.req_addr[1:0] != 2'b00));
  assign size_d = bus.req_size;
  assign addr_d = bus.req_addr;
`else
  assign err_d  = 1'b0;
  assign size_d = (bus.req_size == 2'b11) ? 2'b10 : bus.req_size;
  always_comb begin
    addr_d = bus.req_addr;
    if (size_d == 2'b01)      addr_d[0]   = 1'b0;
    else if (size_d == 2'b10) addr_d[1:0] = 2'b00;
  end
`endif

  assign lane_sh = {addr_q[1:0], 3'b000};
  assign lane    = bus.dmem_rd >> lane_sh;
  assign word_a  = {addr_q[AW-1:2], 2'b00};

  always_comb begin
    case (size_q)
      2'b00:   load_ext = {{24{signed_q & lane[7]}}, lane[7:0]};
      2'b01:   load_ext = {{16{signed_q & lane[15]}}, lane[15:0]};
      default: load_ext = lane;
    endcase
  end

  // For word stores the mask covers everything, so the old word drops out.
  always_comb begin
    case (size_q)
      2'b00:   lane_mask = 32'h0000_00FF << lane_sh;
      2'b01:   lane_mask = 32'h0000_FFFF << lane_sh;
      default: lane_mask = 32'hFFFF_FFFF;
    endcase
    store_word = (old_q & ~lane_mask) | ((wdata_q << lane_sh) & lane_mask);
  end

  always_ff @(posedge clk) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_nx;
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      we_q     <= 1'b0;
      signed_q <= 1'b0;
      err_q    <= 1'b0;
      size_q   <= 2'b00;
      addr_q   <= '0;
      wdata_q  <= '0;
      old_q    <= '0;
      rdata_q  <= '0;
    end else begin
      if (accept) begin
        we_q     <= bus.req_we;
        signed_q <= bus.req_signed;
        err_q    <= err_d;
        size_q   <= size_d;
        addr_q   <= addr_d;
        wdata_q  <= bus.req_wdata;
        rdata_q  <= '0;
      end
      if (state == RD)     rdata_q <= load_ext;
      if (state == RMW_RD) old_q   <= bus.dmem_rd;
    end
  end

  always_comb begin
    state_nx = state;
    ready    = 1'b0;
    rv       = 1'b0;
    dwe      = 1'b0;
    da       = '0;
    dwd      = '0;
    case (state)
      IDLE: begin
        ready = 1'b1;
        if (accept) begin
          if (err_d)                state_nx = RESP;
          else if (!bus.req_we)     state_nx = RD;
          else if (size_d == 2'b10) state_nx = WR;
          else                      state_nx = RMW_RD;
        end
      end
      RD: begin
        da       = word_a;
        state_nx = RESP;
      end
      RMW_RD: begin
        da       = word_a;
        state_nx = WR;
      end
      WR: begin
        dwe      = 1'b1;
        da       = word_a;
        dwd      = store_word;
        state_nx = RESP;
      end
      RESP: begin
        rv       = 1'b1;
        state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  // Every output is gated by reset_n so an asserted reset silences the port mid-cycle.
  assign bus.req_ready  = ready & reset_n;
  assign bus.resp_valid = rv & reset_n;
  assign bus.resp_err   = rv & reset_n & err_q & ~we_q | rv & reset_n & err_q & we_q;
  assign bus.resp_rdata = (rv & reset_n) ? rdata_q : 32'h0;
  assign bus.dmem_we    = dwe & reset_n;
  assign bus.dmem_a     = reset_n ? da : '0;
  assign bus.dmem_wd    = reset_n ? dwd : 32'h0;

endmodule

// File: tb/tb_mem_access_unit.sv
// Self-checking bench for mem_access_unit: directed cases plus randomized accesses
// checked against a byte-array reference model and a small word memory.
module tb_mem_access_unit;
  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  mem_access_if #(.AW(32)) bus();
  mem_access_unit #(.AW(32)) dut (.clk(clk), .reset_n(reset_n), .bus(bus.slave));

  int checks = 0;
  int errors = 0;

  logic [31:0] mem     [64];
  logic [31:0] ref_mem [64];
  logic        pre_we   = 1'b0;
  logic [5:0]  pre_idx  = '0;
  logic [31:0] pre_data = '0;

  assign bus.dmem_rd = mem[bus.dmem_a[7:2]];

  always @(posedge clk) begin
    if (pre_we)           mem[pre_idx] <= pre_data;
    else if (bus.dmem_we) mem[bus.dmem_a[7:2]] <= bus.dmem_wd;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic preload(input int idx, input logic [31:0] d);
    pre_we   = 1'b1;
    pre_idx  = 6'(idx);
    pre_data = d;
    ref_mem[idx] = d;
    @(posedge clk); #1;
    pre_we = 1'b0;
  endtask

  // Reference: memory as little-endian bytes; an access touches n = 1/2/4 bytes from offset off.
  task automatic model(input bit we, input bit [1:0] size, input bit sgn, input logic [31:0] addr,
                       input logic [31:0] wdata, output bit err, output int lat,
                       output logic [31:0] rdata, output bit wr, output logic [31:0] wword,
                       output logic [31:0] waddr);
    int n, off;
    logic [7:0]  b [4];
    logic [31:0] w;
    n   = (size == 2'd0) ? 1 : (size == 2'd1) ? 2 : 4;
    off = int'(addr[1:0]);
`ifdef MEM_ACCESS_ALIGN_CHECK_EN
    err = (size == 2'd3) || (off % n != 0);
`else
    err = 1'b0;
    off = off - (off % n);
`endif
    rdata = '0;
    wr    = 1'b0;
    wword = '0;
    waddr = {addr[31:2], 2'b00};
    w = ref_mem[addr[7:2]];
    for (int k = 0; k < 4; k++) b[k] = w[8*k +: 8];
    if (err) begin
      lat = 1;
    end else if (!we) begin
      lat = 2;
      for (int i = 0; i < n; i++) rdata = rdata | (32'(b[off+i]) << (8*i));
      if (sgn && n < 4 && b[off+n-1][7]) rdata = rdata | ~((32'd1 << (8*n)) - 32'd1);
    end else begin
      lat = (n == 4) ? 2 : 3;
      for (int i = 0; i < n; i++) b[off+i] = wdata[8*i +: 8];
      wword = {b[3], b[2], b[1], b[0]};
      wr = 1'b1;
      ref_mem[addr[7:2]] = wword;
    end
  endtask

  // Called #1 after a rising edge with the unit idle; returns #1 after an edge, idle again.
  task automatic do_access(input bit we, input bit [1:0] size, input bit sgn, input logic [31:0] addr,
                           input logic [31:0] wdata, input bit hold,
                           output logic [31:0] got_rdata, output bit got_err);
    bit          e_err, e_wr, busy_ready, misalign;
    int          e_lat, lat, nw;
    logic [31:0] e_rdata, e_word, e_waddr, wd, wa;
    model(we, size, sgn, addr, wdata, e_err, e_lat, e_rdata, e_wr, e_word, e_waddr);
    bus.req_valid  = 1'b1;
    bus.req_we     = we;
    bus.req_size   = size;
    bus.req_signed = sgn;
    bus.req_addr   = addr;
    bus.req_wdata  = wdata;
    check("ready_at_accept", 32'(bus.req_ready), 32'd1);
    @(posedge clk); #1;
    if (hold) begin
      bus.req_we     = ~we;
      bus.req_size   = 2'($urandom_range(0, 3));
      bus.req_signed = ~sgn;
      bus.req_addr   = $urandom;
      bus.req_wdata  = $urandom;
    end else begin
      bus.req_valid = 1'b0;
    end
    lat = 0; nw = 0; busy_ready = 1'b0; misalign = 1'b0; wd = '0; wa = '0;
    got_rdata = '0; got_err = 1'b0;
    for (int c = 1; c <= 8; c++) begin
      if (c > 1) begin @(posedge clk); #1; end
      if (bus.req_ready) busy_ready = 1'b1;
      if (bus.dmem_a[1:0] != 2'b00) misalign = 1'b1;
      if (bus.dmem_we) begin nw++; wd = bus.dmem_wd; wa = bus.dmem_a; end
      if (bus.resp_valid) begin
        lat = c;
        got_rdata = bus.resp_rdata;
        got_err = bus.resp_err;
        break;
      end
    end
    check("resp_latency", 32'(lat), 32'(e_lat));
    check("resp_err", 32'(got_err), 32'(e_err));
    check("resp_rdata", got_rdata, e_rdata);
    check("write_count", 32'(nw), 32'(e_wr));
    if (e_wr) begin
      check("write_data", wd, e_word);
      check("write_addr", wa, e_waddr);
    end
    check("ready_low_busy", 32'(busy_ready), 32'd0);
    check("dmem_a_aligned", 32'(misalign), 32'd0);
    @(posedge clk); #1;
    bus.req_valid = 1'b0;
    check("ready_after_resp", 32'(bus.req_ready), 32'd1);
    check("resp_one_cycle", 32'(bus.resp_valid), 32'd0);
    check("mem_word", mem[addr[7:2]], ref_mem[addr[7:2]]);
  endtask

  task automatic check_outputs_zero(input string tag);
    check({tag, "_ready"}, 32'(bus.req_ready), 32'd0);
    check({tag, "_rvalid"}, 32'(bus.resp_valid), 32'd0);
    check({tag, "_rdata"}, bus.resp_rdata, 32'd0);
    check({tag, "_rerr"}, 32'(bus.resp_err), 32'd0);
    check({tag, "_dwe"}, 32'(bus.dmem_we), 32'd0);
    check({tag, "_da"}, bus.dmem_a, 32'd0);
    check({tag, "_dwd"}, bus.dmem_wd, 32'd0);
  endtask

  initial begin
    #1000000;
    $display("FAIL global_timeout: observed no finish, required finish");
    $fatal(1, "timeout");
  end

  initial begin
    logic [31:0] r;
    bit          e, wseen, rseen;
    bus.req_valid = 1'b0; bus.req_we = 1'b0; bus.req_size = 2'b00;
    bus.req_signed = 1'b0; bus.req_addr = '0; bus.req_wdata = '0;
    repeat (2) @(posedge clk);
    #1;
    check_outputs_zero("reset");
    for (int i = 0; i < 64; i++) preload(i, $urandom);
    check_outputs_zero("reset_hold");
    reset_n = 1'b1;
    #1;
    check("ready_after_reset", 32'(bus.req_ready), 32'd1);

    do_access(1'b1, 2'd2, 1'b0, 32'h10, 32'hDEADBEEF, 1'b0, r, e);
    do_access(1'b0, 2'd2, 1'b0, 32'h10, 32'h0, 1'b0, r, e);
    check("tp_word_load", r, 32'hDEADBEEF);

    preload(8, 32'h11223344);
    do_access(1'b1, 2'd0, 1'b0, 32'h22, 32'h000000AA, 1'b0, r, e);
    check("tp_byte_rmw", mem[8], 32'h11AA3344);

    preload(12, 32'h80F0017F);
    do_access(1'b0, 2'd0, 1'b1, 32'h30, 32'h0, 1'b0, r, e);
    check("tp_sb_30", r, 32'h0000007F);
    do_access(1'b0, 2'd0, 1'b1, 32'h33, 32'h0, 1'b0, r, e);
    check("tp_sb_33", r, 32'hFFFFFF80);
    do_access(1'b0, 2'd1, 1'b0, 32'h32, 32'h0, 1'b0, r, e);
    check("tp_uh_32", r, 32'h000080F0);
    do_access(1'b0, 2'd1, 1'b1, 32'h32, 32'h0, 1'b0, r, e);
    check("tp_sh_32", r, 32'hFFFF80F0);

    preload(16, 32'h55667788);
    do_access(1'b1, 2'd1, 1'b0, 32'h41, 32'h0000BEEF, 1'b0, r, e);
`ifdef MEM_ACCESS_ALIGN_CHECK_EN
    check("tp_mis_err", 32'(e), 32'd1);
    check("tp_mis_mem", mem[16], 32'h55667788);
`else
    check("tp_mis_err", 32'(e), 32'd0);
    check("tp_mis_mem", mem[16], 32'h5566BEEF);
`endif

    do_access(1'b0, 2'd2, 1'b0, 32'h10, 32'h0, 1'b1, r, e);
    check("tp_hold_load", r, 32'hDEADBEEF);
    do_access(1'b1, 2'd0, 1'b0, 32'h21, 32'h0000005A, 1'b1, r, e);

    // Reset while a byte store sits in RMW_RD.
    preload(20, 32'hCAFEF00D);
    bus.req_valid = 1'b1; bus.req_we = 1'b1; bus.req_size = 2'd0;
    bus.req_signed = 1'b0; bus.req_addr = 32'h51; bus.req_wdata = 32'h12;
    @(posedge clk); #1;
    bus.req_valid = 1'b0;
    reset_n = 1'b0;
    #1;
    check_outputs_zero("rst_rmw");
    wseen = 1'b0; rseen = 1'b0;
    repeat (3) begin
      @(posedge clk); #1;
      if (bus.dmem_we) wseen = 1'b1;
      if (bus.resp_valid) rseen = 1'b1;
    end
    check("rst_no_write", 32'(wseen), 32'd0);
    check("rst_no_resp", 32'(rseen), 32'd0);
    reset_n = 1'b1;
    #1;
    check("rst_ready", 32'(bus.req_ready), 32'd1);
    check("rst_mem_keep", mem[20], 32'hCAFEF00D);
    do_access(1'b0, 2'd0, 1'b0, 32'h51, 32'h0, 1'b0, r, e);
    check("rst_next_load", r, 32'h000000F0);

    for (int i = 0; i < 300; i++) begin
      do_access(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
                32'($urandom_range(0, 255)), $urandom, ($urandom_range(0, 4) == 0), r, e);
      repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
    end

    for (int i = 0; i < 64; i++) check("final_mem", mem[i], ref_mem[i]);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
